// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 / exception definitions for the commit-stage exception controller.
// Optional timer behaviour in exc_ctrl is gated by the CP0_TIMER_EN macro.
package exc_ctrl_pkg;

    typedef enum logic [4:0] {
        CODE_INT = 5'd0,
        ADEL     = 5'd4,
        ADES     = 5'd5,
        SYS      = 5'd8,
        BP       = 5'd9,
        RI       = 5'd10,
        OV       = 5'd12
    } exc_code_t;

    // Source index -> ExcCode; index 0 is the highest priority request line.
    localparam logic [7:0][4:0] EXC_CODE_TBL = {ADES, ADEL, BP, SYS, OV, RI, ADEL, CODE_INT};

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef struct packed {
        logic [8:0] z31_23;
        logic       bev;
        logic [5:0] z21_16;
        logic [7:0] im;
        logic [5:0] z7_2;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] z29_16;
        logic [7:0]  ip;
        logic        z7;
        logic [4:0]  exc_code;
        logic [1:0]  z1_0;
    } cause_t;

    typedef enum logic {ST_RUN, ST_HOLD} exc_state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Commit-stage, CP0 access and redirect signals of the exception controller.
interface exc_ctrl_if #(parameter int N_SRC = 8);
    logic             commit_valid;
    logic [N_SRC-1:0] exc_req;
    logic [31:0]      exc_pc;
    logic [31:0]      exc_vaddr;
    logic             exc_in_ds;
    logic             eret;
    logic             cp0_we;
    logic [4:0]       cp0_waddr;
    logic [31:0]      cp0_wdata;
    logic [4:0]       cp0_raddr;
    logic [31:0]      cp0_rdata;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ready;

    modport master (
        output commit_valid, exc_req, exc_pc, exc_vaddr, exc_in_ds, eret,
               cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, redirect_ready,
        input  cp0_rdata, redirect_valid, redirect_pc
    );

    modport slave (
        input  commit_valid, exc_req, exc_pc, exc_vaddr, exc_in_ds, eret,
               cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, redirect_ready,
        output cp0_rdata, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_ctrl_int_sync.sv
// N_HWINT-wide, SYNC_STAGES-deep synchroniser for the asynchronous interrupt lines.
module exc_ctrl_int_sync #(
    parameter int N_HWINT     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_HWINT-1:0] d,
    output logic [N_HWINT-1:0] q
);
    logic [SYNC_STAGES-1:0][N_HWINT-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/exc_ctrl.sv
// Precise exception / interrupt controller at commit: owns CP0 state and a held redirect.
// Define CP0_TIMER_EN to enable the Count/Compare timer and timer_int.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          N_SRC       = 8,
    parameter int          N_HWINT     = 5,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_ENTRY   = 32'hBFC0_0380
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_HWINT-1:0] hw_int,
    output logic               timer_int,
    exc_ctrl_if.slave          bus
);
    exc_state_t  state, state_nxt;
    logic [7:0]  im;
    logic        exl, ie, bd, ti;
    logic [4:0]  code;
    logic [1:0]  ip_sw;
    logic [31:0] epc, badv, count, cmp, redirect_pc_q;
    logic [N_HWINT-1:0] hw_sync;
    logic [5:0]  hw_ip;
    logic [7:0]  ip;
    logic        src_any, int_pend, take, eret_go, cp0_wr;
    logic [2:0]  src_idx;
    logic [4:0]  exc_code;
    logic        unused_wdata;

    exc_ctrl_int_sync #(.N_HWINT(N_HWINT), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .resetn(resetn), .d(hw_int), .q(hw_sync)
    );

    assign hw_ip    = 6'(hw_sync);
    assign ip       = {hw_ip[5] | ti, hw_ip[4:0], ip_sw};
    assign int_pend = (|(ip & im)) && ie && !exl;

    always_comb begin
        src_any = 1'b0;
        src_idx = '0;
        for (int i = N_SRC-1; i >= 0; i--) begin
            if (bus.exc_req[i]) begin
                src_any = 1'b1;
                src_idx = 3'(i);
            end
        end
    end

    // HOLD is wrong-path: no takes, erets or MTC0 until the redirect is accepted.
    assign take     = (state == ST_RUN) && bus.commit_valid && (int_pend || src_any);
    assign eret_go  = (state == ST_RUN) && bus.eret && !take;
    assign cp0_wr   = (state == ST_RUN) && bus.cp0_we && !take;
    assign exc_code = int_pend ? 5'(CODE_INT) : EXC_CODE_TBL[src_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (take || eret_go)   state_nxt = ST_HOLD;
            ST_HOLD: if (bus.redirect_ready) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign bus.redirect_valid = (state == ST_HOLD);
    assign bus.redirect_pc    = redirect_pc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im <= '0; exl <= 1'b0; ie <= 1'b0;
            bd <= 1'b0; code <= '0; ip_sw <= '0;
            epc <= '0; badv <= '0; cmp <= '0; redirect_pc_q <= '0;
        end else begin
            if (cp0_wr) begin
                case (bus.cp0_waddr)
                    CP0_STATUS: begin
                        im  <= bus.cp0_wdata[15:8];
                        exl <= bus.cp0_wdata[1];
                        ie  <= bus.cp0_wdata[0];
                    end
                    CP0_CAUSE:   ip_sw <= bus.cp0_wdata[9:8];
                    CP0_EPC:     epc   <= bus.cp0_wdata;
                    CP0_COMPARE: cmp   <= bus.cp0_wdata;
                    default: ;
                endcase
            end
            if (take) begin
                // A nested exception keeps the original return context.
                if (!exl) begin
                    epc <= bus.exc_in_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
                    bd  <= bus.exc_in_ds;
                end
                code <= exc_code;
                exl  <= 1'b1;
                if (exc_code == ADEL || exc_code == ADES) badv <= bus.exc_vaddr;
                redirect_pc_q <= EXC_ENTRY;
            end else if (eret_go) begin
                exl           <= 1'b0;
                redirect_pc_q <= epc;
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0; tick <= 1'b0; ti <= 1'b0;
        end else begin
            tick <= ~tick;
            if (cp0_wr && bus.cp0_waddr == CP0_COUNT) begin
                count <= bus.cp0_wdata;
            end else if (tick) begin
                count <= count + 32'd1;
                if (count + 32'd1 == cmp) ti <= 1'b1;
            end
            if (cp0_wr && bus.cp0_waddr == CP0_COMPARE) ti <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                     count <= '0;
        else if (cp0_wr && bus.cp0_waddr == CP0_COUNT) count <= bus.cp0_wdata;
    end
    assign ti = 1'b0;
`endif

    assign timer_int    = ti;
    assign unused_wdata = ^bus.cp0_wdata;

    always_comb begin
        status_t sr;
        cause_t  cr;
        sr = '0; sr.bev = 1'b1; sr.im = im; sr.exl = exl; sr.ie = ie;
        cr = '0; cr.bd = bd; cr.ti = ti; cr.ip = ip; cr.exc_code = code;
        bus.cp0_rdata = '0;
        case (bus.cp0_raddr)
            CP0_STATUS:   bus.cp0_rdata = sr;
            CP0_CAUSE:    bus.cp0_rdata = cr;
            CP0_EPC:      bus.cp0_rdata = epc;
            CP0_BADVADDR: bus.cp0_rdata = badv;
            CP0_COUNT:    bus.cp0_rdata = count;
            CP0_COMPARE:  bus.cp0_rdata = cmp;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl; timer checks follow CP0_TIMER_EN.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] hw_int;
    logic       timer_int;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [31:0] rv;

    exc_ctrl_if #(.N_SRC(8)) bus ();

    exc_ctrl dut (
        .clk(clk), .resetn(resetn), .hw_int(hw_int), .timer_int(timer_int), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.cp0_raddr = a;
        #1;
        d = bus.cp0_rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we = 1'b1; bus.cp0_waddr = a; bus.cp0_wdata = d;
        step();
        bus.cp0_we = 1'b0;
    endtask

    task automatic commit(input logic [7:0] req, input logic [31:0] pc, input logic ds);
        bus.commit_valid = 1'b1; bus.exc_req = req; bus.exc_pc = pc; bus.exc_in_ds = ds;
        step();
        bus.commit_valid = 1'b0; bus.exc_req = '0; bus.exc_in_ds = 1'b0;
    endtask

    task automatic accept();
        bus.redirect_ready = 1'b1;
        step();
        bus.redirect_ready = 1'b0;
        chk("ready_drop", {31'd0, bus.redirect_valid}, 32'd0);
    endtask

    initial begin
        int k;
        resetn = 1'b0; hw_int = '0;
        bus.commit_valid = 0; bus.exc_req = '0; bus.exc_pc = '0; bus.exc_vaddr = '0;
        bus.exc_in_ds = 0; bus.eret = 0; bus.cp0_we = 0; bus.cp0_waddr = '0;
        bus.cp0_wdata = '0; bus.cp0_raddr = '0; bus.redirect_ready = 0;
        repeat (3) step();
        chk("rst_rv",  {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_rpc", bus.redirect_pc, 32'd0);
        rd(CP0_STATUS, rv); chk("rst_status", rv, 32'h0040_0000);
        rd(CP0_CAUSE, rv);  chk("rst_cause", rv, 32'd0);
        rd(CP0_COUNT, rv);  chk("rst_count", rv, 32'd0);
        resetn = 1'b1;
        step();

        // RI from source 2
        commit(8'b0000_0100, 32'h8000_1010, 1'b0);
        chk("ri_rv",  {31'd0, bus.redirect_valid}, 32'd1);
        chk("ri_rpc", bus.redirect_pc, 32'hBFC0_0380);
        rd(CP0_EPC, rv);    chk("ri_epc", rv, 32'h8000_1010);
        rd(CP0_CAUSE, rv);  chk("ri_cause", rv, 32'h0000_0028);
        rd(CP0_STATUS, rv); chk("ri_status", rv, 32'h0040_0002);
        accept();

        // ADEL fetch in delay slot beats ADES; BEV stays read-only
        mtc0(CP0_STATUS, 32'd0);
        rd(CP0_STATUS, rv); chk("bev_ro", rv, 32'h0040_0000);
        bus.exc_vaddr = 32'hDEAD_BEE1;
        commit(8'b1000_0010, 32'h8000_2004, 1'b1);
        rd(CP0_CAUSE, rv);    chk("adel_cause", rv, 32'h8000_0010);
        rd(CP0_EPC, rv);      chk("adel_epc", rv, 32'h8000_2000);
        rd(CP0_BADVADDR, rv); chk("adel_badv", rv, 32'hDEAD_BEE1);

        // HOLD ignores wrong-path activity
        for (int i = 0; i < 5; i++) begin
            bus.commit_valid = 1; bus.exc_req = 8'h01; bus.eret = 1;
            bus.cp0_we = 1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h1234;
            step();
            chk("hold_rpc", bus.redirect_pc, 32'hBFC0_0380);
            chk("hold_rv", {31'd0, bus.redirect_valid}, 32'd1);
        end
        bus.commit_valid = 0; bus.exc_req = '0; bus.eret = 0; bus.cp0_we = 0;
        rd(CP0_EPC, rv);   chk("hold_epc", rv, 32'h8000_2000);
        rd(CP0_CAUSE, rv); chk("hold_cause", rv, 32'h8000_0010);
        accept();

        // Nested SYS with EXL=1 keeps EPC and BD
        commit(8'b0001_0000, 32'h8000_5000, 1'b0);
        rd(CP0_EPC, rv);   chk("nest_epc", rv, 32'h8000_2000);
        rd(CP0_CAUSE, rv); chk("nest_cause", rv, 32'h8000_0020);
        accept();

        // ERET
        mtc0(CP0_EPC, 32'h8000_3000);
        bus.eret = 1; bus.commit_valid = 1;
        step();
        bus.eret = 0; bus.commit_valid = 0;
        chk("eret_rpc", bus.redirect_pc, 32'h8000_3000);
        rd(CP0_STATUS, rv); chk("eret_status", rv, 32'h0040_0000);
        accept();

        // Take beats same-cycle ERET and drops same-cycle MTC0
        bus.eret = 1; bus.cp0_we = 1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h1111;
        commit(8'b0000_0100, 32'h8000_4000, 1'b0);
        bus.eret = 0; bus.cp0_we = 0;
        chk("eret_exc_rpc", bus.redirect_pc, 32'hBFC0_0380);
        rd(CP0_EPC, rv);   chk("eret_exc_epc", rv, 32'h8000_4000);
        rd(CP0_CAUSE, rv); chk("eret_exc_cause", rv, 32'h0000_0028);
        accept();

        // hw_int[1] -> IP3 after the synchroniser
        mtc0(CP0_STATUS, 32'h0000_0801);
        hw_int = 5'b00010; bus.commit_valid = 1; bus.exc_pc = 32'h8000_6000;
        step(); chk("int_s1", {31'd0, bus.redirect_valid}, 32'd0);
        step(); chk("int_s2", {31'd0, bus.redirect_valid}, 32'd0);
        step(); chk("int_take", {31'd0, bus.redirect_valid}, 32'd1);
        bus.commit_valid = 0;
        rd(CP0_CAUSE, rv);  chk("int_cause", rv, 32'h0000_0800);
        rd(CP0_EPC, rv);    chk("int_epc", rv, 32'h8000_6000);
        rd(CP0_STATUS, rv); chk("int_status", rv, 32'h0040_0803);
        accept();
        bus.commit_valid = 1;
        repeat (3) step();
        chk("int_exl_block", {31'd0, bus.redirect_valid}, 32'd0);
        bus.commit_valid = 0; hw_int = '0;

        // Timer
        mtc0(CP0_STATUS, 32'd0);
        mtc0(CP0_COMPARE, 32'd4);
        mtc0(CP0_COUNT, 32'd0);
`ifdef CP0_TIMER_EN
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (timer_int && k == 0) k = i;
        end
        chk("ti_lat", {31'd0, (k >= 7 && k <= 9)}, 32'd1);
        chk("ti_sticky", {31'd0, timer_int}, 32'd1);
        mtc0(CP0_COMPARE, 32'd4);
        chk("ti_clr", {31'd0, timer_int}, 32'd0);
`else
        k = 0;
        repeat (10) step();
        rd(CP0_COUNT, rv); chk("count_frozen", rv, 32'd0);
        chk("ti_off", {31'd0, timer_int}, 32'd0);
`endif

        // Asynchronous reset mid-HOLD abandons the redirect
        commit(8'b0000_1000, 32'h8000_7000, 1'b0);
        chk("pre_rst_rv", {31'd0, bus.redirect_valid}, 32'd1);
        #1 resetn = 1'b0;
        #1 chk("rst_hold_rv", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_hold_rpc", bus.redirect_pc, 32'd0);
        step();
        resetn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
